door_ctrl: RTL and testbench
============================

DOOR_CTRL -- requirements
Module: door_ctrl

Interface
REQ-001 SHALL take parameter TIMEOUT, default 1000, cycles a motor may run before a fault is declared (legal range 2..2^20).
REQ-002 SHALL take parameter AUTO_CLOSE, default 0, cycles in OPEN before an automatic close; 0 disables auto-close.
REQ-003 SHALL have port clk  input  1  system clock, all state updates on the rising edge.
REQ-004 SHALL have port r  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port b  input  1  user button, level; only rising edges act.
REQ-006 SHALL have port c  input  1  closed limit switch, high = door fully closed.
REQ-007 SHALL have port o  input  1  open limit switch, high = door fully open.
REQ-008 SHALL have port s  input  1  obstruction sensor, high = path blocked.
REQ-009 SHALL have port u  output  1  motor up (open); registered.
REQ-010 SHALL have port d  output  1  motor down (close); registered.
REQ-011 SHALL have port fault  output  1  high while in FAULT; registered.
REQ-012 SHALL have port State  output  3  current state code, for debug/verification.

Function
REQ-013 SHALL encode states CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, FAULT=4, INIT=5; codes 6-7 SHALL go to INIT on the next edge.
REQ-014 SHALL derive b_rise = b AND NOT b_q, with b_q a one-cycle registered copy of b; a held button acts once.
REQ-015 SHALL make outputs Moore: u=1 only in OPENING, d=1 only in CLOSING, fault=1 only in FAULT, all updated in the same edge as State; u and d SHALL never both be 1.
REQ-016 INIT: c AND o -> FAULT; else c -> CLOSED; else o -> OPEN; else -> OPENING.
REQ-017 CLOSED: b_rise -> OPENING; else stay.
REQ-018 OPENING: o -> OPEN; else timer = TIMEOUT-1 -> FAULT; else stay.
REQ-019 OPEN: (b_rise OR (AUTO_CLOSE>0 AND timer = AUTO_CLOSE-1)) AND NOT s -> CLOSING; else stay.
REQ-020 CLOSING: s OR b_rise -> OPENING (priority over c); else c -> CLOSED; else timer = TIMEOUT-1 -> FAULT; else stay.
REQ-021 FAULT: b_rise -> INIT; else stay; limit switches ignored.
REQ-022 SHALL keep one up-counter timer, width ceil(log2(max(TIMEOUT,AUTO_CLOSE,2)))+1, cleared on every state change, incrementing each cycle in OPENING, CLOSING and OPEN, held at 0 elsewhere.
REQ-023 In OPEN, s high SHALL clear timer each cycle, restarting the auto-close interval after the obstruction clears.
REQ-024 Timer SHALL saturate, never wrap.
REQ-025 c and o both high in OPENING or CLOSING SHALL go to FAULT, overriding REQ-018/REQ-020.

Reset
REQ-026 r high SHALL immediately force State=INIT, u=0, d=0, fault=0, timer=0, b_q=0, independent of clk.
REQ-027 First clk edge after r falls SHALL evaluate INIT per REQ-016; reset mid-motion SHALL stop the motor at once.

Structure
REQ-028 SHALL place the state-code constants and the 3-bit state typedef in shared package door_ctrl_pkg.
REQ-029 SHALL implement b_rise in sub-module rise_detect (clk, r, in, rise), reusable by other blocks.

Verification (bench TIMEOUT=20, AUTO_CLOSE=10)
REQ-030 Reset with c=1, release, pulse b 1 cycle -> State 0 then 1, u=1; o=1 after 5 cycles -> State 2, u=0.
REQ-031 In OPEN, b=0, s=0 -> State 3, d=1 exactly 10 cycles after entering OPEN; s=1 at cycle 6 then 0 -> close 10 cycles after s falls.
REQ-032 In CLOSING, s=1 with c=1 same cycle -> State 1, u=1, d=0 (obstruction wins).
REQ-033 In OPENING, o never rises -> State 4, fault=1, u=0 after 20 cycles; b held high 5 cycles -> single transition to INIT.
REQ-034 r asserted between clk edges while CLOSING -> d=0, State=5 before next edge; release with c=0, o=0 -> State 1, u=1.
REQ-035 Reset release with c=1, o=1 -> State 4, fault=1.

Source files
------------

// File: rtl/door_ctrl_pkg.sv
// Shared definitions for the door controller: state codes and timer sizing.
package door_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  // State codes are externally visible on State, so the encoding is fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_CLOSED  = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_FAULT   = 3'd4,
    ST_INIT    = 3'd5
  } state_t;

  // Timer width: one bit more than needed for the largest interval,
  // which leaves headroom for the saturating counter.
  function automatic int unsigned timer_width(input int unsigned timeout,
                                              input int unsigned auto_close);
    int unsigned m;
    m = timeout;
    if (auto_close > m) m = auto_close;
    if (m < 2) m = 2;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level input.
// Ports:
//   clk  - clock
//   r    - asynchronous active-high reset (clears the delayed copy)
//   in   - level input
//   rise - high for the cycle in which 'in' is high and was low last cycle
module rise_detect (
  input  logic clk,
  input  logic r,
  input  logic in,
  output logic rise
);

  logic r_q;

  // One-cycle delayed copy of the input.
  always_ff @(posedge clk or posedge r) begin
    if (r) r_q <= 1'b0;
    else   r_q <= in;
  end

  assign rise = in & ~r_q;

endmodule

// File: rtl/door_ctrl.sv
// Motorised door controller: drives the up/down motor from a push button,
// two limit switches and an obstruction sensor, with a motor-run timeout
// and optional automatic closing.
// Parameters:
//   TIMEOUT    - cycles a motor may run before FAULT (2..2^20)
//   AUTO_CLOSE - cycles in OPEN before automatic close, 0 disables
// Ports:
//   clk   - clock, rising edge
//   r     - asynchronous active-high reset
//   b     - user button (level, rising edge acts)
//   c     - closed limit switch
//   o     - open limit switch
//   s     - obstruction sensor
//   u     - motor up, registered
//   d     - motor down, registered
//   fault - high while in FAULT, registered
//   State - current state code
module door_ctrl
  import door_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 1000,
  parameter int unsigned AUTO_CLOSE = 0
) (
  input  logic               clk,
  input  logic               r,
  input  logic               b,
  input  logic               c,
  input  logic               o,
  input  logic               s,
  output logic               u,
  output logic               d,
  output logic               fault,
  output logic [STATE_W-1:0] State
);

  localparam int unsigned   TW      = timer_width(TIMEOUT, AUTO_CLOSE);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  // Guarded so a disabled auto-close never produces a wrapped constant.
  localparam logic [TW-1:0] AC_LAST = TW'((AUTO_CLOSE > 0) ? (AUTO_CLOSE - 1) : 0);
  localparam logic          AC_EN   = (AUTO_CLOSE > 0);

  state_t        r_state;
  state_t        w_next_state;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic          r_u;
  logic          r_d;
  logic          r_fault;

  logic          w_b_rise;
  logic          w_both_limits;
  logic          w_to_expired;
  logic          w_ac_expired;
  logic          w_counting;

  // Button edge detection, shared with other blocks.
  rise_detect u_btn_rise (
    .clk  (clk),
    .r    (r),
    .in   (b),
    .rise (w_b_rise)
  );

  assign w_both_limits = c & o;
  assign w_to_expired  = (r_timer == TO_LAST);
  assign w_ac_expired  = AC_EN & (r_timer == AC_LAST);
  assign w_counting    = (r_state == ST_OPENING) || (r_state == ST_OPEN) ||
                         (r_state == ST_CLOSING);

  // Next-state and next-timer logic.
  always_comb begin
    w_next_state = r_state;
    w_timer_next = '0;

    case (r_state)
      ST_INIT: begin
        if (w_both_limits) w_next_state = ST_FAULT;
        else if (c)        w_next_state = ST_CLOSED;
        else if (o)        w_next_state = ST_OPEN;
        else               w_next_state = ST_OPENING;
      end
      ST_CLOSED: begin
        if (w_b_rise) w_next_state = ST_OPENING;
      end
      ST_OPENING: begin
        // Contradictory limit switches override normal progress.
        if (w_both_limits)     w_next_state = ST_FAULT;
        else if (o)            w_next_state = ST_OPEN;
        else if (w_to_expired) w_next_state = ST_FAULT;
      end
      ST_OPEN: begin
        if ((w_b_rise || w_ac_expired) && !s) w_next_state = ST_CLOSING;
      end
      ST_CLOSING: begin
        // Obstruction or button reverses before the closed switch is honoured.
        if (w_both_limits)      w_next_state = ST_FAULT;
        else if (s || w_b_rise) w_next_state = ST_OPENING;
        else if (c)             w_next_state = ST_CLOSED;
        else if (w_to_expired)  w_next_state = ST_FAULT;
      end
      ST_FAULT: begin
        if (w_b_rise) w_next_state = ST_INIT;
      end
      default: begin
        w_next_state = ST_INIT;
      end
    endcase

    // Timer restarts on every state change and while OPEN is obstructed;
    // it saturates rather than wrapping.
    if ((w_next_state == r_state) && w_counting &&
        !((r_state == ST_OPEN) && s)) begin
      if (r_timer == '1) w_timer_next = r_timer;
      else               w_timer_next = r_timer + TW'(1);
    end
  end

  // State, timer and Moore outputs all update on the same edge.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_state <= ST_INIT;
      r_timer <= '0;
      r_u     <= 1'b0;
      r_d     <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_timer <= w_timer_next;
      r_u     <= (w_next_state == ST_OPENING);
      r_d     <= (w_next_state == ST_CLOSING);
      r_fault <= (w_next_state == ST_FAULT);
    end
  end

  assign u     = r_u;
  assign d     = r_d;
  assign fault = r_fault;
  assign State = r_state;

endmodule

// File: tb/tb_door_ctrl.sv
// Testbench for door_ctrl: directed scenarios plus randomized stimulus,
// compared every cycle against a behavioural model of the door.
module tb_door_ctrl;

  localparam int unsigned TIMEOUT    = 20;
  localparam int unsigned AUTO_CLOSE = 10;

  logic       clk = 1'b0;
  logic       r   = 1'b0;
  logic       b   = 1'b0;
  logic       c   = 1'b0;
  logic       o   = 1'b0;
  logic       s   = 1'b0;
  logic       u;
  logic       d;
  logic       fault;
  logic [2:0] State;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit cmp_en   = 1'b0;

  door_ctrl #(
    .TIMEOUT    (TIMEOUT),
    .AUTO_CLOSE (AUTO_CLOSE)
  ) dut (
    .clk   (clk),
    .r     (r),
    .b     (b),
    .c     (c),
    .o     (o),
    .s     (s),
    .u     (u),
    .d     (d),
    .fault (fault),
    .State (State)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Door model: state codes 0..5, m_age = edges spent in the current state
  // (restarted while the open door is obstructed).
  int m_state = 5;
  int m_age   = 0;
  bit m_bq    = 1'b0;

  function automatic int model_next(input int st, input int age, input bit brise,
                                    input bit lc, input bit lo, input bit obs);
    bit both;
    both = lc && lo;
    case (st)
      0: return brise ? 1 : 0;
      1: begin
        if (both) return 4;
        if (lo) return 2;
        if (age == int'(TIMEOUT) - 1) return 4;
        return 1;
      end
      2: begin
        if (obs) return 2;
        if (brise) return 3;
        if (AUTO_CLOSE > 0 && age == int'(AUTO_CLOSE) - 1) return 3;
        return 2;
      end
      3: begin
        if (both) return 4;
        if (obs || brise) return 1;
        if (lc) return 0;
        if (age == int'(TIMEOUT) - 1) return 4;
        return 3;
      end
      4: return brise ? 5 : 4;
      default: begin
        if (both) return 4;
        if (lc) return 0;
        if (lo) return 2;
        return 1;
      end
    endcase
  endfunction

  function automatic int model_age(input int st, input int age, input int nx, input bit obs);
    if (nx != st) return 0;
    if (st == 2 && obs) return 0;
    if (st == 1 || st == 2 || st == 3) return age + 1;
    return 0;
  endfunction

  always @(posedge clk or posedge r) begin
    if (r) begin
      m_state <= 5;
      m_age   <= 0;
      m_bq    <= 1'b0;
    end else begin
      m_state <= model_next(m_state, m_age, b && !m_bq, c, o, s);
      m_age   <= model_age(m_state, m_age,
                           model_next(m_state, m_age, b && !m_bq, c, o, s), s);
      m_bq    <= b;
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("cyc_state", 32'(State), 32'(m_state));
      check("cyc_u",     32'(u),     32'(m_state == 1));
      check("cyc_d",     32'(d),     32'(m_state == 3));
      check("cyc_fault", 32'(fault), 32'(m_state == 4));
      check("cyc_ud_excl", 32'(u & d), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset with door closed.
    #1;
    r = 1'b1;
    c = 1'b1;
    cmp_en = 1'b1;
    #1;
    check("rst_state", 32'(State), 32'd5);
    check("rst_u",     32'(u),     32'd0);
    check("rst_d",     32'(d),     32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    @(negedge clk);
    r = 1'b0;
    step();
    check("init_closed", 32'(State), 32'd0);
    check("model_closed", 32'(m_state), 32'd0);

    // Button pulse opens the door.
    @(negedge clk);
    b = 1'b1;
    step();
    check("open_start_state", 32'(State), 32'd1);
    check("open_start_u",     32'(u),     32'd1);
    @(negedge clk);
    b = 1'b0;
    c = 1'b0;
    repeat (4) step();
    @(negedge clk);
    o = 1'b1;
    step();
    check("open_reached_state", 32'(State), 32'd2);
    check("open_reached_u",     32'(u),     32'd0);
    check("model_open",         32'(m_state), 32'd2);

    // Auto-close exactly AUTO_CLOSE cycles after entering OPEN.
    for (int k = 1; k <= 10; k++) begin
      step();
      check("autoclose_state", 32'(State), (k == 10) ? 32'd3 : 32'd2);
    end
    check("autoclose_d", 32'(d), 32'd1);

    // Obstruction together with closed switch reverses the door.
    @(negedge clk);
    o = 1'b0;
    s = 1'b1;
    c = 1'b1;
    step();
    check("obs_wins_state", 32'(State), 32'd1);
    check("obs_wins_u",     32'(u),     32'd1);
    check("obs_wins_d",     32'(d),     32'd0);

    // Obstruction in OPEN restarts the auto-close interval.
    @(negedge clk);
    s = 1'b0;
    c = 1'b0;
    o = 1'b1;
    step();
    check("reopen_state", 32'(State), 32'd2);
    repeat (5) step();
    @(negedge clk);
    s = 1'b1;
    repeat (3) step();
    check("obstructed_open", 32'(State), 32'd2);
    @(negedge clk);
    s = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step();
      check("restart_close_state", 32'(State), (j == 10) ? 32'd3 : 32'd2);
    end

    // Reset between edges while closing stops the motor at once.
    step();
    check("closing_before_rst", 32'(d), 32'd1);
    r = 1'b1;
    #1;
    check("midrst_d",     32'(d),     32'd0);
    check("midrst_state", 32'(State), 32'd5);
    @(negedge clk);
    r = 1'b0;
    o = 1'b0;
    c = 1'b0;
    step();
    check("midrst_release_state", 32'(State), 32'd1);
    check("midrst_release_u",     32'(u),     32'd1);

    // Opening never completes: FAULT after TIMEOUT cycles.
    for (int k = 1; k <= 20; k++) begin
      step();
      check("timeout_state", 32'(State), (k == 20) ? 32'd4 : 32'd1);
    end
    check("timeout_fault", 32'(fault), 32'd1);
    check("timeout_u",     32'(u),     32'd0);

    // Held button leaves FAULT exactly once.
    @(negedge clk);
    b = 1'b1;
    c = 1'b1;
    step();
    check("held_b_init", 32'(State), 32'd5);
    step();
    check("held_b_closed", 32'(State), 32'd0);
    repeat (3) step();
    check("held_b_no_retrigger", 32'(State), 32'd0);
    @(negedge clk);
    b = 1'b0;
    step();
    check("release_b_closed", 32'(State), 32'd0);

    // Both limit switches at reset release.
    @(negedge clk);
    r = 1'b1;
    c = 1'b1;
    o = 1'b1;
    @(negedge clk);
    r = 1'b0;
    step();
    check("both_limits_state", 32'(State), 32'd4);
    check("both_limits_fault", 32'(fault), 32'd1);
    check("model_fault",       32'(m_state), 32'd4);
    @(negedge clk);
    b = 1'b1;
    step();
    check("fault_exit_init", 32'(State), 32'd5);
    @(negedge clk);
    b = 1'b0;
    c = 1'b0;
    o = 1'b0;
    step();
    check("init_opening", 32'(State), 32'd1);

    // Randomized stimulus, checked by the per-cycle compare.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) b = ~b;
      c = ($urandom_range(0, 9) == 0);
      o = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    r = 1'b0;
    step();
    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
